// File: rtl/batch_accumulator.sv
// batch_accumulator: sequential reduction stage behind the 32-bit adder datapath.
// It accumulates a stream of WIDTH-bit words into a running sum. A batch closes after COUNT
// words or on a handshaken in_last. The block then presents the sum, the word count and a
// sticky carry flag until downstream accepts them.
//
// Optional build macro: BATCH_ACC_SATURATE_EN
//   defined   -> the accumulator saturates to all-ones on carry out
//   undefined -> the accumulator wraps modulo 2^WIDTH (default)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word present
//   in_ready   high while accumulating (ACC state)
//   in_data    operand word
//   in_last    closes the batch early; only honoured together with a handshake
//   out_valid  batch result present (HOLD state)
//   out_ready  downstream accepts the result
//   out_sum    batch sum
//   out_count  number of words in the batch
//   out_cout   sticky carry out of bit WIDTH-1 seen during the batch
module batch_accumulator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned COUNT = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_sum,
  output logic [$clog2(COUNT+1)-1:0]     out_count,
  output logic                           out_cout
);

  localparam int unsigned CntW = $clog2(COUNT + 1);

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cflag_q, cflag_d;

  logic [WIDTH:0]    sum;
  logic [CntW:0]     cnt_inc;
  logic              in_fire;
  logic              batch_close;

  assign sum         = {1'b0, acc_q} + {1'b0, in_data};
  assign cnt_inc     = {1'b0, cnt_q} + (CntW + 1)'(1);
  assign in_fire     = in_valid & in_ready;
  assign batch_close = in_last | (cnt_inc == (CntW + 1)'(COUNT));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cflag_d = cflag_q;
    unique case (state_q)
      StAcc: begin
        if (in_fire) begin
`ifdef BATCH_ACC_SATURATE_EN
          // Once saturated, any nonzero add carries again, so acc stays all-ones.
          acc_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
          acc_d = sum[WIDTH-1:0];
`endif
          cnt_d   = cnt_inc[CntW-1:0];
          cflag_d = cflag_q | sum[WIDTH];
          if (batch_close) state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          cflag_d = 1'b0;
          state_d = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      cflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cflag_q <= cflag_d;
    end
  end

  // All outputs come straight from state; no input-to-output combinational path.
  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StHold);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_cout  = cflag_q;

endmodule
